// File: rtl/dmem_store_scheduler.sv
// Store buffer and dual-port scheduler in front of data_memory: loads take ports first, buffered stores drain through idle ports.
// Build option SB_FORWARD_EN enables store-to-load forwarding; without it a load that matches a buffered store stalls until that store drains.
module dmem_store_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    output logic                   st_ready,
    input  logic                   ld0_valid,
    input  logic [AW-1:0]          ld0_addr,
    output logic [DW-1:0]          ld0_data,
    output logic                   ld0_done,
    input  logic                   ld1_valid,
    input  logic [AW-1:0]          ld1_addr,
    output logic [DW-1:0]          ld1_data,
    output logic                   ld1_done,
    output logic                   ld_stall,
    input  logic                   fence_req,
    output logic                   fence_done,
    output logic [$clog2(DEPTH):0] sb_count,
    output logic [AW-1:0]          mem_address0,
    output logic [AW-1:0]          mem_address1,
    output logic                   mem_read0,
    output logic                   mem_read1,
    output logic                   mem_write0,
    output logic                   mem_write1,
    output logic [DW-1:0]          mem_wdata0,
    output logic [DW-1:0]          mem_wdata1,
    input  logic [DW-1:0]          mem_rdata0,
    input  logic [DW-1:0]          mem_rdata1
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FULL   = 2'd1,
        ST_FENCE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    sb_entry_t     sb_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head1;
    logic [CW-1:0] count;
    logic          push;
    logic          two_ok;
    logic [1:0]    drained;
    logic [1:0]    hit;
    logic          hazard;
    logic          idle0;
    logic          idle1;
    logic [AW-1:0] ld_addr [2];
`ifdef SB_FORWARD_EN
    logic [DW-1:0] hit_data [2];
`endif

    assign ld_addr[0] = ld0_addr;
    assign ld_addr[1] = ld1_addr;
    assign st_ready   = (count < CW'(DEPTH)) && (state != ST_FENCE);
    assign push       = st_valid && st_ready;
    assign sb_count   = count;
    assign head1      = head + PW'(1);
    assign two_ok     = (count >= CW'(2)) && (sb_mem[head].addr != sb_mem[head1].addr);

    // Address match per load pipe; scan oldest to youngest so the last hit wins, the same-cycle push is youngest.
    always_comb begin
        hit = '0;
`ifdef SB_FORWARD_EN
        hit_data[0] = '0;
        hit_data[1] = '0;
`endif
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ((CW'(i) < count) && (sb_mem[head + PW'(i)].addr == ld_addr[p])) begin
                    hit[p] = 1'b1;
`ifdef SB_FORWARD_EN
                    hit_data[p] = sb_mem[head + PW'(i)].data;
`endif
                end
            end
            if (push && (st_addr == ld_addr[p])) begin
                hit[p] = 1'b1;
`ifdef SB_FORWARD_EN
                hit_data[p] = st_data;
`endif
            end
        end
    end

`ifdef SB_FORWARD_EN
    assign hazard = 1'b0;
`else
    assign hazard = (ld0_valid && hit[0]) || (ld1_valid && hit[1]);
`endif

    assign ld_stall = (state != ST_NORMAL) || hazard;

    // Mode FSM: next state and fence completion pulse.
    always_comb begin
        state_nxt  = state;
        fence_done = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (fence_req) begin
                    state_nxt = ST_FENCE;
                end else if (count == CW'(DEPTH)) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (count < CW'(DEPTH)) begin
                    state_nxt = ST_NORMAL;
                end
            end
            ST_FENCE: begin
                if (count == '0) begin
                    fence_done = fence_req;
                    state_nxt  = ST_NORMAL;
                end
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    // Port assignment: loads first, then in-order drain from head through whichever ports are left idle.
    always_comb begin
        ld0_done     = 1'b0;
        ld1_done     = 1'b0;
        ld0_data     = '0;
        ld1_data     = '0;
        mem_read0    = 1'b0;
        mem_read1    = 1'b0;
        mem_write0   = 1'b0;
        mem_write1   = 1'b0;
        mem_address0 = '0;
        mem_address1 = '0;
        mem_wdata0   = '0;
        mem_wdata1   = '0;
        idle0        = 1'b1;
        idle1        = 1'b1;
        drained      = 2'd0;

        if (ld0_valid && !ld_stall) begin
            ld0_done = 1'b1;
`ifdef SB_FORWARD_EN
            if (hit[0]) begin
                ld0_data = hit_data[0];
            end else
`endif
            begin
                idle0        = 1'b0;
                mem_read0    = 1'b1;
                mem_address0 = ld0_addr;
                ld0_data     = mem_rdata0;
            end
        end

        if (ld1_valid && !ld_stall) begin
            ld1_done = 1'b1;
`ifdef SB_FORWARD_EN
            if (hit[1]) begin
                ld1_data = hit_data[1];
            end else
`endif
            begin
                idle1        = 1'b0;
                mem_read1    = 1'b1;
                mem_address1 = ld1_addr;
                ld1_data     = mem_rdata1;
            end
        end

        // Two same-address entries never drain together, so write order to memory is preserved.
        if (count != '0) begin
            if (idle0) begin
                mem_write0   = 1'b1;
                mem_address0 = sb_mem[head].addr;
                mem_wdata0   = sb_mem[head].data;
                drained      = 2'd1;
                if (idle1 && two_ok) begin
                    mem_write1   = 1'b1;
                    mem_address1 = sb_mem[head1].addr;
                    mem_wdata1   = sb_mem[head1].data;
                    drained      = 2'd2;
                end
            end else if (idle1) begin
                mem_write1   = 1'b1;
                mem_address1 = sb_mem[head].addr;
                mem_wdata1   = sb_mem[head].data;
                drained      = 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_NORMAL;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            head  <= head + PW'(drained);
            if (push) begin
                tail <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(drained);
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            sb_mem[tail] <= '{addr: st_addr, data: st_data};
        end
    end

endmodule

// File: tb/tb_dmem_store_scheduler.sv
// Scenario bench for dmem_store_scheduler: expected memory writes are queued at push time and matched against observed port writes.
module tb_dmem_store_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld0_valid;
    logic [AW-1:0] ld0_addr;
    logic [DW-1:0] ld0_data;
    logic          ld0_done;
    logic          ld1_valid;
    logic [AW-1:0] ld1_addr;
    logic [DW-1:0] ld1_data;
    logic          ld1_done;
    logic          ld_stall;
    logic          fence_req;
    logic          fence_done;
    logic [2:0]    sb_count;
    logic [AW-1:0] mem_address0;
    logic [AW-1:0] mem_address1;
    logic          mem_read0;
    logic          mem_read1;
    logic          mem_write0;
    logic          mem_write1;
    logic [DW-1:0] mem_wdata0;
    logic [DW-1:0] mem_wdata1;
    logic [DW-1:0] mem_rdata0;
    logic [DW-1:0] mem_rdata1;

    logic [DW-1:0] tbmem [256];
    logic [255:0]  wr_seen = '0;
    logic [31:0]   exp_wq [$];
    logic [31:0]   obs_q  [$];
    int            n_cmp = 0;
    int            n_err = 0;

    dmem_store_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld0_valid(ld0_valid), .ld0_addr(ld0_addr), .ld0_data(ld0_data), .ld0_done(ld0_done),
        .ld1_valid(ld1_valid), .ld1_addr(ld1_addr), .ld1_data(ld1_data), .ld1_done(ld1_done),
        .ld_stall(ld_stall), .fence_req(fence_req), .fence_done(fence_done), .sb_count(sb_count),
        .mem_address0(mem_address0), .mem_address1(mem_address1),
        .mem_read0(mem_read0), .mem_read1(mem_read1),
        .mem_write0(mem_write0), .mem_write1(mem_write1),
        .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
    );

    always #5 clock = ~clock;

    // Unwritten locations read back as 0xC0xx so load results are predictable.
    assign mem_rdata0 = wr_seen[mem_address0[7:0]] ? tbmem[mem_address0[7:0]] : (16'hC000 | {8'h00, mem_address0[7:0]});
    assign mem_rdata1 = wr_seen[mem_address1[7:0]] ? tbmem[mem_address1[7:0]] : (16'hC000 | {8'h00, mem_address1[7:0]});

    always @(posedge clock) begin
        if (mem_write0) begin
            tbmem[mem_address0[7:0]]   <= mem_wdata0;
            wr_seen[mem_address0[7:0]] <= 1'b1;
            obs_q.push_back({mem_address0, mem_wdata0});
        end
        if (mem_write1) begin
            tbmem[mem_address1[7:0]]   <= mem_wdata1;
            wr_seen[mem_address1[7:0]] <= 1'b1;
            obs_q.push_back({mem_address1, mem_wdata1});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ld0_valid = 1'b0;
        ld0_addr  = '0;
        ld1_valid = 1'b0;
        ld1_addr  = '0;
        fence_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", sb_count); end
        n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL reset_ld_stall: got %b want 0", ld_stall); end
        n_cmp++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL reset_fence_done: got %b want 0", fence_done); end
        n_cmp++;
        if ({mem_read0, mem_read1, mem_write0, mem_write1} !== 4'b0000) begin
            n_err++; $display("FAIL reset_strobes: got %b want 0000", {mem_read0, mem_read1, mem_write0, mem_write1});
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single_drain();
        logic [31:0] exp_e;
        logic [31:0] obs_e;
        @(negedge clock);
        st_valid = 1'b1; st_addr = 16'h0002; st_data = 16'h0080;
        #1;
        if (st_valid && st_ready) exp_wq.push_back({st_addr, st_data});
        n_cmp++; if (mem_write0 !== 1'b0) begin n_err++; $display("FAIL single_push_cycle_write: got %b want 0", mem_write0); end
        @(negedge clock);
        st_valid = 1'b0;
        #1;
        n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", sb_count); end
        n_cmp++; if (mem_write0 !== 1'b1) begin n_err++; $display("FAIL single_write0: got %b want 1", mem_write0); end
        n_cmp++; if (mem_address0 !== 16'h0002) begin n_err++; $display("FAIL single_addr0: got %h want 0002", mem_address0); end
        n_cmp++; if (mem_wdata0 !== 16'h0080) begin n_err++; $display("FAIL single_wdata0: got %h want 0080", mem_wdata0); end
        n_cmp++; if (mem_write1 !== 1'b0) begin n_err++; $display("FAIL single_write1: got %b want 0", mem_write1); end
        @(negedge clock);
        #1;
        n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", sb_count); end
        while (exp_wq.size() != 0) begin
            exp_e = exp_wq.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL single_order: got no write want %h", exp_e); end
            else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin n_err++; $display("FAIL single_order: got %h want %h", obs_e, exp_e); end
            end
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp_e;
        logic [31:0] obs_e;
        @(negedge clock);
        st_valid = 1'b1; st_addr = 16'h0003; st_data = 16'h0100;
        ld0_valid = 1'b1; ld0_addr = 16'h0003;
        #1;
        if (st_valid && st_ready) exp_wq.push_back({st_addr, st_data});
        n_cmp++; if (mem_read0 !== 1'b0) begin n_err++; $display("FAIL fwd_read0: got %b want 0", mem_read0); end
`ifdef SB_FORWARD_EN
        n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL fwd_stall: got %b want 0", ld_stall); end
        n_cmp++; if (ld0_done !== 1'b1) begin n_err++; $display("FAIL fwd_done: got %b want 1", ld0_done); end
        n_cmp++; if (ld0_data !== 16'h0100) begin n_err++; $display("FAIL fwd_data: got %h want 0100", ld0_data); end
`else
        n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL haz_stall0: got %b want 1", ld_stall); end
        n_cmp++; if (ld0_done !== 1'b0) begin n_err++; $display("FAIL haz_done0: got %b want 0", ld0_done); end
`endif
        @(negedge clock);
        st_valid = 1'b0;
`ifdef SB_FORWARD_EN
        ld0_valid = 1'b0;
`endif
        #1;
        n_cmp++; if (mem_write0 !== 1'b1) begin n_err++; $display("FAIL fwd_drain_write: got %b want 1", mem_write0); end
        n_cmp++; if (mem_address0 !== 16'h0003) begin n_err++; $display("FAIL fwd_drain_addr: got %h want 0003", mem_address0); end
`ifndef SB_FORWARD_EN
        n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL haz_stall1: got %b want 1", ld_stall); end
        @(negedge clock);
        #1;
        n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL haz_release: got %b want 0", ld_stall); end
        n_cmp++; if (mem_read0 !== 1'b1) begin n_err++; $display("FAIL haz_read0: got %b want 1", mem_read0); end
        n_cmp++; if (ld0_data !== 16'h0100) begin n_err++; $display("FAIL haz_data: got %h want 0100", ld0_data); end
`endif
        idle_inputs();
        for (int c = 0; c < 20 && sb_count != 3'd0; c++) begin @(negedge clock); #1; end
        while (exp_wq.size() != 0) begin
            exp_e = exp_wq.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL fwd_order: got no write want %h", exp_e); end
            else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin n_err++; $display("FAIL fwd_order: got %h want %h", obs_e, exp_e); end
            end
        end
    endtask

    task automatic test_same_addr();
        logic [31:0]   exp_e;
        logic [31:0]   obs_e;
        logic [DW-1:0] got;
        logic          served;
        logic          dup;
        served = 1'b0; dup = 1'b0; got = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            st_valid = 1'b1; st_addr = 16'h0010; st_data = (c == 0) ? 16'h1111 : 16'h2222;
            ld0_valid = 1'b1; ld0_addr = 16'h0040;
            ld1_valid = 1'b1; ld1_addr = 16'h0041;
            #1;
            if (st_valid && st_ready) exp_wq.push_back({st_addr, st_data});
            if (c == 0) begin
                n_cmp++; if (ld0_data !== 16'hC040) begin n_err++; $display("FAIL load_path0: got %h want c040", ld0_data); end
                n_cmp++; if (ld1_data !== 16'hC041) begin n_err++; $display("FAIL load_path1: got %h want c041", ld1_data); end
                n_cmp++; if (mem_read1 !== 1'b1) begin n_err++; $display("FAIL load_read1: got %b want 1", mem_read1); end
            end
        end
        for (int c = 0; c < 10 && !served; c++) begin
            @(negedge clock);
            st_valid = 1'b0;
            ld1_addr = 16'h0010;
            #1;
            if (mem_write0 && mem_write1 && (mem_address0 == mem_address1)) dup = 1'b1;
            if (ld1_done) begin served = 1'b1; got = ld1_data; end
        end
        n_cmp++; if (!served) begin n_err++; $display("FAIL same_served: got timeout want ld1_done"); end
        n_cmp++; if (got !== 16'h2222) begin n_err++; $display("FAIL same_youngest: got %h want 2222", got); end
        idle_inputs();
        for (int c = 0; c < 20 && sb_count != 3'd0; c++) begin
            @(negedge clock); #1;
            if (mem_write0 && mem_write1 && (mem_address0 == mem_address1)) dup = 1'b1;
        end
        n_cmp++; if (dup !== 1'b0) begin n_err++; $display("FAIL same_dual_write: got %b want 0", dup); end
        while (exp_wq.size() != 0) begin
            exp_e = exp_wq.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL same_order: got no write want %h", exp_e); end
            else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin n_err++; $display("FAIL same_order: got %h want %h", obs_e, exp_e); end
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_e;
        logic [31:0] obs_e;
        logic [7:0]  exp_ready = 8'b1100_1111;
        logic [7:0]  exp_stall = 8'b0110_0000;
        logic [7:0]  exp_w2    = 8'b0110_0000;
        int          exp_cnt [8] = '{0, 1, 2, 3, 4, 4, 2, 1};
        int          npush = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            st_valid = (npush < 5);
            st_addr  = 16'h0050 + 16'(npush);
            st_data  = 16'hA000 + 16'(npush);
            ld0_valid = 1'b1; ld0_addr = 16'h0040;
            ld1_valid = 1'b1; ld1_addr = 16'h0041;
            #1;
            n_cmp++; if (sb_count !== 3'(exp_cnt[c])) begin n_err++; $display("FAIL full_count c%0d: got %0d want %0d", c, sb_count, exp_cnt[c]); end
            n_cmp++; if (st_ready !== exp_ready[c]) begin n_err++; $display("FAIL full_st_ready c%0d: got %b want %b", c, st_ready, exp_ready[c]); end
            n_cmp++; if (ld_stall !== exp_stall[c]) begin n_err++; $display("FAIL full_stall c%0d: got %b want %b", c, ld_stall, exp_stall[c]); end
            n_cmp++;
            if ({mem_write0, mem_write1} !== {exp_w2[c], exp_w2[c]}) begin
                n_err++; $display("FAIL full_writes c%0d: got %b%b want %b%b", c, mem_write0, mem_write1, exp_w2[c], exp_w2[c]);
            end
            if (st_valid && st_ready) begin
                exp_wq.push_back({st_addr, st_data});
                npush++;
            end
        end
        idle_inputs();
        for (int c = 0; c < 20 && sb_count != 3'd0; c++) begin @(negedge clock); #1; end
        n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL full_drain: got %0d want 0", sb_count); end
        while (exp_wq.size() != 0) begin
            exp_e = exp_wq.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL full_order: got no write want %h", exp_e); end
            else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin n_err++; $display("FAIL full_order: got %h want %h", obs_e, exp_e); end
            end
        end
    endtask

    task automatic test_fence();
        logic [31:0] exp_e;
        logic [31:0] obs_e;
        int          done_k = -1;
        int          pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            st_valid = 1'b1; st_addr = 16'h0060 + 16'(c); st_data = 16'hB000 + 16'(c);
            ld0_valid = 1'b1; ld0_addr = 16'h0040;
            ld1_valid = 1'b1; ld1_addr = 16'h0041;
            #1;
            if (st_valid && st_ready) exp_wq.push_back({st_addr, st_data});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            st_valid  = 1'b0;
            fence_req = (done_k < 0);
            #1;
            if (k == 1) begin
                n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL fence_stall: got %b want 1", ld_stall); end
                n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL fence_st_ready: got %b want 0", st_ready); end
                n_cmp++; if (ld0_done !== 1'b0) begin n_err++; $display("FAIL fence_ld0_done: got %b want 0", ld0_done); end
            end
            if (fence_done) begin
                pulses++;
                if (done_k < 0) done_k = k;
                n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL fence_done_count: got %0d want 0", sb_count); end
                fence_req = 1'b0;
            end
        end
        n_cmp++; if (done_k != 3) begin n_err++; $display("FAIL fence_done_cycle: got %0d want 3", done_k); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL fence_pulses: got %0d want 1", pulses); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL fence_resume: got %b want 0", ld_stall); end
        idle_inputs();
        while (exp_wq.size() != 0) begin
            exp_e = exp_wq.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL fence_order: got no write want %h", exp_e); end
            else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin n_err++; $display("FAIL fence_order: got %h want %h", obs_e, exp_e); end
            end
        end
    endtask

    task automatic test_fence_empty();
        @(negedge clock);
        idle_inputs();
        fence_req = 1'b1;
        #1;
        n_cmp++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL fence0_early: got %b want 0", fence_done); end
        @(negedge clock);
        #1;
        n_cmp++; if (fence_done !== 1'b1) begin n_err++; $display("FAIL fence0_pulse: got %b want 1", fence_done); end
        n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL fence0_stall: got %b want 1", ld_stall); end
        fence_req = 1'b0;
        @(negedge clock);
        #1;
        n_cmp++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL fence0_after: got %b want 0", fence_done); end
        n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL fence0_ready: got %b want 1", st_ready); end
    endtask

    task automatic test_reset_mid_fence();
        int pulses = 0;
        obs_q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            st_valid = 1'b1; st_addr = 16'h0070 + 16'(c); st_data = 16'hD000 + 16'(c);
            ld0_valid = 1'b1; ld0_addr = 16'h0040;
            ld1_valid = 1'b1; ld1_addr = 16'h0041;
        end
        @(negedge clock);
        st_valid  = 1'b0;
        fence_req = 1'b1;
        #1;
        n_cmp++; if (sb_count !== 3'd2) begin n_err++; $display("FAIL rstf_count_before: got %0d want 2", sb_count); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL rstf_count: got %0d want 0", sb_count); end
        n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL rstf_st_ready: got %b want 1", st_ready); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL rstf_stall: got %b want 0", ld_stall); end
        n_cmp++; if ({mem_write0, mem_write1} !== 2'b00) begin n_err++; $display("FAIL rstf_writes: got %b%b want 00", mem_write0, mem_write1); end
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            if (fence_done) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstf_fence_done: got %0d want 0", pulses); end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rstf_writes_after: got %0d want 0", obs_q.size()); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_drain();
        test_forward();
        test_same_addr();
        test_full();
        test_fence();
        test_fence_empty();
        test_reset_mid_fence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_store_scheduler.md
# dmem_store_scheduler

Store-buffer and port scheduler in front of the dual-port `data_memory` in the superscalar core. Retired stores are queued in an in-order FIFO. Each cycle the block gives memory ports to the two load pipes first, then drains buffered stores through any idle port. It also forwards buffered store data to matching loads, throttles loads when the buffer is full, and executes a drain fence.

## Interface
- `DEPTH`, 4: store-buffer entries, power of two, 2..16.
- `AW`, 16: address width.
- `DW`, 16: data width.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  retired store push request.
- `st_addr`  in  AW  store address.
- `st_data`  in  DW  store data.
- `st_ready`  out  1  buffer can accept a push; push happens on `st_valid && st_ready`.
- `ld0_valid`, `ld1_valid`  in  1  load request, pipe 0 and pipe 1.
- `ld0_addr`, `ld1_addr`  in  AW  load address.
- `ld0_data`, `ld1_data`  out  DW  load result, valid when `ldN_done`.
- `ld0_done`, `ld1_done`  out  1  load completed this cycle.
- `ld_stall`  out  1  loads not accepted this cycle; pipes hold their requests.
- `fence_req`  in  1  drain-all request, level, held until `fence_done`.
- `fence_done`  out  1  one-cycle pulse when the buffer empties under a fence.
- `sb_count`  out  log2(DEPTH)+1  occupied entries.
- `mem_address0`, `mem_address1`  out  AW  memory port addresses.
- `mem_read0`, `mem_read1`, `mem_write0`, `mem_write1`  out  1  memory port strobes.
- `mem_wdata0`, `mem_wdata1`  out  DW  memory write data.
- `mem_rdata0`, `mem_rdata1`  in  DW  memory read data; combinational, same cycle.

## Operation
- Buffer: circular FIFO with `head`, `tail` and `count`. Entries hold address and data.
- `st_ready` = (`count` < `DEPTH`) && state != FENCE. It depends on registered state only; a drain in the same cycle does not raise it.
- States and transitions:
  - NORMAL: move to FULL when `count` == `DEPTH`. Move to FENCE when `fence_req` is high. FENCE has priority over FULL.
  - FULL: `ld_stall`=1, and both ports drain. Return to NORMAL when `count` < `DEPTH`.
  - FENCE: `ld_stall`=1, `st_ready`=0, and both ports drain. When `count` reaches 0, pulse `fence_done` and return to NORMAL.
- Port mapping in NORMAL:
  - Port 0 serves `ld0` and port 1 serves `ld1`.
  - A load that hits the buffer is served from the buffer and does not use its port.
  - A port is idle when its load pipe is invalid or was forwarded.
- Forwarding match: compare the load address against every valid entry and against the same-cycle push (`st_valid && st_ready`). The youngest match wins and the same-cycle push counts as youngest.
  - On a match, `ldN_data` = the matched data and `ldN_done`=1, with `mem_readN`=0.
  - With no match, `mem_readN`=1 and `ldN_data` = `mem_rdataN`, `ldN_done`=1.
- Drain, taken from the head in order:
  - With one idle port, the head drains on that port.
  - With two idle ports, the head drains on port 0 and head+1 drains on port 1. Exception: if both entries share an address, only the head drains that cycle. The block never issues two same-address writes in one cycle.
- Drain and load in the same cycle: a drained entry remains a forwarding source in that cycle.
- Count update: `count` ← `count` + push − drained, where drained is 0..2.
- Outputs when idle: `mem_*` strobes are 0. `ldN_data`, `mem_wdataN` and `mem_addressN` are 0.

## Timing
- Load latency is 0 cycles: `ldN_done` is asserted combinationally in the cycle of `ldN_valid` when `ld_stall` is 0. `ld_stall` depends on state only.
- Push latency: an entry is visible to the drain logic from the cycle after the push, and to forwarding in the same cycle.
- Reset asserted (low), immediately and asynchronously:
  - `count`, `head` and `tail` go to 0 and the state goes to NORMAL.
  - Buffered stores are discarded.
  - Outputs settle to: `st_ready`=1, `ld_stall`=0, `fence_done`=0, all `mem_*` strobes 0.
- Reset in mid-fence: the fence is abandoned and no `fence_done` is issued.
- A fence raised with `count`==0 pulses `fence_done` in the next cycle.
- `fence_req` dropped before completion: return to NORMAL when `count`==0, with no pulse.

## Configuration
- `SB_FORWARD_EN` defined: store-to-load forwarding works as described in Operation.
- `SB_FORWARD_EN` undefined: no forwarding.
  - A load whose address matches any entry or the same-cycle push raises `ld_stall` for that cycle and for every following cycle until the matching store has drained.
  - Drains continue on both ports while this stall is active.

## Test plan
- Reset, push store (0x0002, 0x0080) with no loads → next cycle `mem_write0`=1, `mem_address0`=0x0002, `mem_wdata0`=0x0080; `count` goes 1→0.
- Push (0x0003, 0x0100), then in the same cycle a `ld0` to 0x0003 → `ld0_data`=0x0100, `mem_read0`=0. With `SB_FORWARD_EN` undefined: `ld_stall`=1 until the drain.
- Two pushes to 0x0010 (0x1111 then 0x2222), then `ld1` to 0x0010 → `ld1_data`=0x2222; on drain the two writes occur in separate cycles, 0x1111 first.
- Fill to `DEPTH`=4 with both loads continuously valid → FULL, `ld_stall`=1, two writes per cycle, `st_ready` rises only once `count`<4.
- `fence_req` with 3 entries and both loads valid → loads stalled, `fence_done` pulses in the cycle `count` reaches 0.
- Assert `reset` mid-fence with 2 entries → `count`=0 immediately, no writes afterwards, no `fence_done`.
